// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the registered N:1 mux.
// Used by mux_n_1_seq and its testbench.
package mux_pkg;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MANUAL,
        ST_SCAN
    } state_t;
endpackage

// File: rtl/mod_counter.sv
// Modulo-MODULUS wrap-around counter with synchronous load.
// Drives the scan index of mux_n_1_seq.
module mod_counter #(
    parameter  int MODULUS = 4,
    localparam int CW      = $clog2(MODULUS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] loadValue,
    input  logic          inc,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] LP_LAST = CW'(MODULUS - 1);

    logic [CW-1:0] r_count;

    // Explicit wrap keeps non-power-of-two moduli inside [0, MODULUS-1]
    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (load)
            r_count <= loadValue;
        else if (inc)
            r_count <= (r_count == LP_LAST) ? '0 : r_count + CW'(1);
    end

    assign count = r_count;
endmodule

// File: rtl/mux_n_1_seq.sv
// Registered N:1 mux with manual select and round-robin scan modes.
// All outputs come straight from flops; one-cycle latency.
module mux_n_1_seq
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] inputData,
    input  logic [SEL_W-1:0]          selection,
    input  logic                      mode,
    input  logic                      enable,
    output logic [WIDTH-1:0]          outputData,
    output logic                      outputValid,
    output logic [SEL_W-1:0]          channel
);
    localparam logic [SEL_W:0]   LP_CH   = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(CHANNELS - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SEL_W-1:0] r_channel;

    logic [WIDTH-1:0] w_ch [CHANNELS];
    logic             w_in_range;
    logic [SEL_W-1:0] w_start;
    logic [SEL_W-1:0] w_idx;
    logic [SEL_W-1:0] w_count;
    logic [SEL_W-1:0] w_load_val;
    logic             w_scan_cont;
    logic             w_scan_entry;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slice
        assign w_ch[k] = inputData[k*WIDTH +: WIDTH];
    end

    assign w_in_range   = ({1'b0, selection} < LP_CH);
    assign w_start      = w_in_range ? selection : '0;
    assign w_scan_cont  = enable && (mode == MODE_SCAN) && (r_state == ST_SCAN);
    assign w_scan_entry = enable && (mode == MODE_SCAN) && (r_state != ST_SCAN);
    // Out-of-range manual selects fall back to index 0 here; their data is zeroed below
    assign w_idx        = w_scan_cont ? w_count : w_start;
    assign w_load_val   = (w_start == LP_LAST) ? '0 : w_start + SEL_W'(1);

    mod_counter #(.MODULUS(CHANNELS)) u_scan_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (w_scan_entry),
        .loadValue (w_load_val),
        .inc       (w_scan_cont),
        .count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_channel <= '0;
        end else if (enable) begin
            r_state   <= (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
            r_channel <= (mode == MODE_SCAN) ? w_idx : selection;
            if ((mode == MODE_SCAN) || w_in_range) begin
                r_data  <= w_ch[w_idx];
                r_valid <= 1'b1;
            end else begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign outputData  = r_data;
    assign outputValid = r_valid;
    assign channel     = r_channel;
endmodule
